// File: rtl/corr_sweep_ctrl.sv
// Purpose: steps the correlation scorer over a raster grid of start positions and keeps the best score.
// Latency: 2 cycles to first oStart after iGo, then 4 cycles plus scorer time per position.
// Backpressure: waits on the scorer's iDone level per pass; iGo is ignored while a sweep is busy.
module corr_sweep_ctrl #(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 64,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 48,
  parameter int STEP    = 1,
  parameter int SCORE_W = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iGo,
  input  logic               iDone,
  input  logic [SCORE_W-1:0] iScore,
  output logic [12:0]        oXstart,
  output logic [12:0]        oYstart,
  output logic               oStart,
  output logic               oBusy,
  output logic               oValid,
  output logic [12:0]        oBestX,
  output logic [12:0]        oBestY,
  output logic [SCORE_W-1:0] oBestScore,
  output logic [15:0]        oCount,
  output logic               oTimeout
);

  typedef enum logic [2:0] {
    IDLE, INIT, ISSUE, WAIT_CLR, WAIT_DONE, COMPARE, NEXT, DONE
  } state_t;

  localparam logic [12:0] XMIN13 = 13'(X_MIN);
  localparam logic [12:0] YMIN13 = 13'(Y_MIN);
  localparam logic [13:0] XMAX14 = 14'(X_MAX);
  localparam logic [13:0] YMAX14 = 14'(Y_MAX);
  localparam logic [13:0] STEP14 = 14'(STEP);
  localparam logic [31:0] TMO32  = 32'(TIMEOUT);

  state_t      state, stateNxt;
  logic [12:0] xCur, yCur;
  logic [13:0] xStep, yStep;
  logic        xAdv, yAdv;
  logic [31:0] tmoCnt;
  logic        tmoHit, tmoEvt;

  // Candidate next position, one bit wider than the coordinates so the limit test cannot wrap.
  assign xStep = {1'b0, xCur} + STEP14;
  assign yStep = {1'b0, yCur} + STEP14;
  assign xAdv  = (xStep <= XMAX14);
  assign yAdv  = (yStep <= YMAX14);
  assign tmoHit = (tmoCnt >= TMO32);

  assign oXstart = xCur;
  assign oYstart = yCur;
  assign oStart  = (state == ISSUE);
  assign oBusy   = (state != IDLE) && (state != DONE);
  assign oValid  = (state == DONE);

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNxt;
  end

  // Next-state decode; a pass abandoned on timeout skips COMPARE entirely.
  always_comb begin
    stateNxt = state;
    tmoEvt   = 1'b0;
    unique case (state)
      IDLE:      if (iGo) stateNxt = INIT;
      INIT:      stateNxt = ISSUE;
      ISSUE:     stateNxt = WAIT_CLR;
      WAIT_CLR: begin
        if (tmoHit) begin
          stateNxt = NEXT;
          tmoEvt   = 1'b1;
        end else if (!iDone) begin
          stateNxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (iDone) begin
          stateNxt = COMPARE;
        end else if (tmoHit) begin
          stateNxt = NEXT;
          tmoEvt   = 1'b1;
        end
      end
      COMPARE:   stateNxt = NEXT;
      NEXT:      stateNxt = (xAdv || yAdv) ? ISSUE : DONE;
      DONE:      if (iGo) stateNxt = INIT;
      default:   stateNxt = IDLE;
    endcase
  end

  // Position walk, pass timer, best-score tracking and sweep statistics.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      xCur       <= XMIN13;
      yCur       <= YMIN13;
      tmoCnt     <= '0;
      oBestX     <= '0;
      oBestY     <= '0;
      oBestScore <= '0;
      oCount     <= '0;
      oTimeout   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          xCur       <= XMIN13;
          yCur       <= YMIN13;
          oBestX     <= XMIN13;
          oBestY     <= YMIN13;
          oBestScore <= '0;
          oCount     <= '0;
          oTimeout   <= 1'b0;
        end
        // The ISSUE cycle counts as the first cycle of the pass.
        ISSUE: tmoCnt <= 32'd1;
        WAIT_CLR, WAIT_DONE: begin
          tmoCnt <= tmoCnt + 32'd1;
          if (tmoEvt) oTimeout <= 1'b1;
        end
        COMPARE: begin
          // Strict compare so ties keep the earlier raster position.
          if (iScore > oBestScore) begin
            oBestScore <= iScore;
            oBestX     <= xCur;
            oBestY     <= yCur;
          end
          if (oCount != 16'hFFFF) oCount <= oCount + 16'd1;
        end
        NEXT: begin
          if (xAdv) begin
            xCur <= xStep[12:0];
          end else if (yAdv) begin
            xCur <= XMIN13;
            yCur <= yStep[12:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/corr_sweep_ctrl.md
Name: corr_sweep_ctrl

Overview:
- Sequences the correlation scorer across a rectangular grid of candidate start positions.
- For each position it presents the start coordinates, triggers one scoring pass and waits for that pass to complete.
- It keeps the highest score and its coordinates, then reports the best match to the tracking/display logic.
- It sits between the top-level frame control and the correlation scorer.

Parameters:
- X_MIN, 0: first candidate X start.
- X_MAX, 64: last candidate X start, inclusive.
- Y_MIN, 0: first candidate Y start.
- Y_MAX, 48: last candidate Y start, inclusive.
- STEP, 1: grid stride in X and Y. Legal range 1..255.
- SCORE_W, 32: score width.
- TIMEOUT, 65535: maximum cycles spent waiting for one pass before that position is abandoned.

Ports:
- iCLK  in  1  50 MHz clock.
- iRST_N  in  1  asynchronous, active-low reset.
- iGo  in  1  sweep request. Sampled only in IDLE and DONE.
- iDone  in  1  scorer finished flag, level.
- iScore  in  SCORE_W  scorer result. Valid while iDone=1.
- oXstart  out  13  candidate X start to the scorer.
- oYstart  out  13  candidate Y start to the scorer.
- oStart  out  1  one-cycle pass trigger.
- oBusy  out  1  sweep in progress.
- oValid  out  1  best result valid; held until the next sweep starts.
- oBestX  out  13  X of the best score.
- oBestY  out  13  Y of the best score.
- oBestScore  out  SCORE_W  best score.
- oCount  out  16  passes completed in the current/last sweep.
- oTimeout  out  1  sticky: at least one pass timed out this sweep.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0, except oXstart=X_MIN and oYstart=Y_MIN.
  - Reset mid-sweep aborts immediately. There is no result retention.
- States and transitions:
  - IDLE: iGo=1 -> INIT.
  - INIT, 1 cycle:
    - Load X=X_MIN, Y=Y_MIN.
    - Clear best score to 0, best coordinates to X_MIN/Y_MIN, oCount=0, oTimeout=0, oValid=0.
    - Set oBusy=1.
    - Go to ISSUE.
  - ISSUE, 1 cycle:
    - oXstart/oYstart already hold X/Y.
    - oStart=1 for exactly this cycle.
    - Go to WAIT_CLR.
  - WAIT_CLR: wait for iDone=0, which confirms the scorer accepted the new start.
    - Then go to WAIT_DONE.
    - The timeout counter runs from ISSUE.
  - WAIT_DONE: wait for iDone=1.
    - On iDone=1: go to COMPARE.
    - Timeout: if the counter reaches TIMEOUT in WAIT_CLR or WAIT_DONE, set oTimeout, skip COMPARE (score discarded, oCount not incremented) and go to NEXT.
  - COMPARE, 1 cycle:
    - If iScore > best score (strict), capture iScore, X and Y.
    - Ties keep the earlier position in raster order.
    - Increment oCount, saturating at 16'hFFFF.
    - Go to NEXT.
  - NEXT, 1 cycle: compute next X and next Y in 14-bit arithmetic, so there is no wrap.
    - If X+STEP <= X_MAX: X += STEP.
    - Else if Y+STEP <= Y_MAX: X=X_MIN, Y += STEP.
    - Else go to DONE.
    - Otherwise go to ISSUE.
  - DONE:
    - oBusy=0 and oValid=1.
    - oBest* held.
    - iGo=1 -> INIT, which drops oValid the next cycle.
- Timing and interface rules:
  - Minimum per-position overhead outside the scorer is 4 cycles (ISSUE, WAIT_CLR, COMPARE, NEXT).
  - oXstart/oYstart change only in NEXT and INIT. They are stable from ISSUE through COMPARE.
  - iGo asserted while busy is ignored. No queuing.
- Degenerate grids:
  - If X_MAX < X_MIN or Y_MAX < Y_MIN, the behaviour is undefined.
  - A single-point grid (MIN=MAX) gives exactly one pass.
- An iScore of 0 at every position still yields oValid=1, with best coordinates equal to the first position.

Test Plan:
- Grid X 0..2, Y 0..1, STEP=1; scorer model returns score = 10*Y+X, done 20 cycles after oStart -> 6 oStart pulses in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); oBestX=2, oBestY=1, oBestScore=12, oCount=6, oValid=1, oBusy=0.
- Same grid, all scores 500 -> oBestX=0, oBestY=0, oBestScore=500 (tie keeps the first position).
- STEP=2, X 0..5, Y 0..3 -> positions X∈{0,2,4}, Y∈{0,2}; oCount=6; no position >5 or >3 issued.
- TIMEOUT=50; model never raises iDone at (1,0), scores 7 elsewhere -> oTimeout=1, oCount=5, sweep completes, oBestScore=7.
- Assert iRST_N=0 during the third pass -> all outputs 0 (oXstart/oYstart = X_MIN/Y_MIN) asynchronously. After release plus iGo, a full 6-pass sweep runs normally.
- iGo pulsed during a sweep, then again in DONE -> the first pulse is ignored; the second starts a new sweep, oValid=0 the cycle after, and oCount restarts from 0.
